sdram_arbit: RTL and testbench
==============================

# sdram_arbit

Central SDRAM command arbiter. It sits directly upstream of the init, write and read engines and owns the physical SDRAM command/address pins. It generates the periodic auto-refresh request and executes the refresh itself. It grants the bus to the write or read engine through level handshakes (`wr_req`/`wr_en`/`flag_wr_end`, `rd_req`/`rd_en`/`flag_rd_end`) and muxes the granted engine's command, address and bank onto the SDRAM pins.

## Interface
Parameters:
- `REF_INTERVAL`, default 390: sclk cycles between refresh requests (7.8 µs at 50 MHz).
- `TRFC`, default 7: cycles counted after AREF issue before returning to arbitration. Must be ≥ 2.

Ports:
- `sclk` in 1: clock.
- `s_rst_n` in 1: reset, asynchronous, active-low.
- `init_end` in 1: init sequence done; level, held high.
- `init_cmd` in 4, `init_addr` in 13: init engine command/address.
- `wr_req` in 1, `flag_wr_end` in 1, `wr_cmd` in 4, `wr_addr` in 13, `wr_bank_addr` in 2: write engine.
- `wr_en` out 1: write grant.
- `rd_req` in 1, `flag_rd_end` in 1, `rd_cmd` in 4, `rd_addr` in 13, `rd_bank_addr` in 2: read engine.
- `rd_en` out 1: read grant.
- `ref_req` out 1: refresh pending; also fed to the write and read engines so they terminate early.
- `sdram_cke` out 1.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: command pins, ordered {cs_n, ras_n, cas_n, we_n}.
- `sdram_bank` out 2.
- `sdram_addr` out 13.

## Operation
- FSM is one-hot, 5 states: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ. Reset state is S_INIT.
- Transitions:
  - S_INIT → S_ARBIT when `init_end`=1.
  - S_ARBIT → S_AREF if `ref_req`; else S_WRITE if `wr_req`; else S_READ if `rd_req`; else stay. Refresh always wins.
  - S_AREF → S_ARBIT when `aref_cnt`==TRFC.
  - S_WRITE → S_ARBIT on `flag_wr_end`. S_READ → S_ARBIT on `flag_rd_end`. Pending `ref_req` never preempts these states; the engines see `ref_req` and terminate themselves.
- `wr_en` = (state==S_WRITE). `rd_en` = (state==S_READ). Both are combinational from the state register and mutually exclusive.
- Refresh timer:
  - Counter `ref_cnt` is held at 0 while state==S_INIT.
  - Otherwise it is free-running 0..REF_INTERVAL-1 and wraps to 0.
  - At `ref_cnt`==REF_INTERVAL-1, register `ref_req` is set to 1.
  - `ref_req` clears on the cycle S_ARBIT→S_AREF is taken.
  - If set and clear coincide, set wins.
  - A second expiry while `ref_req` is already 1 is absorbed; there is no count.
- Refresh execution:
  - `aref_cnt` increments each cycle in S_AREF and is 0 elsewhere.
  - Registered `aref_cmd` = 0001 (AREF) when state==S_AREF and `aref_cnt`==0; otherwise 0111 (NOP).
- Output mux (combinational on state):

  | State | Command | Address | Bank |
  |---|---|---|---|
  | S_INIT | `init_cmd` | `init_addr` | 0 |
  | S_AREF | `aref_cmd` | 0 | 0 |
  | S_WRITE | `wr_cmd` | `wr_addr` | `wr_bank_addr` |
  | S_READ | `rd_cmd` | `rd_addr` | `rd_bank_addr` |
  | S_ARBIT | 0111 | 0 | 0 |

- `sdram_cke` is constant 1.

## Timing
- Reset values:
  - state S_INIT; `ref_cnt`, `aref_cnt`, `ref_req`, `wr_en`, `rd_en` = 0; `aref_cmd` = NOP.
  - Pins follow `init_cmd`/`init_addr` (the init engine drives NOP in reset); `sdram_bank`=0; `sdram_cke`=1.
- Grant latency: request seen in S_ARBIT at cycle N → grant high at N+1. The end flag at M → grant low at M+1, with S_ARBIT at M+1.
- Minimum one S_ARBIT cycle between any two grants.
- Mux latency is 0 cycles: engine command/address reach the pins in the same cycle. This preserves the read engine's CAS-latency alignment.
- S_AREF dwell is TRFC+1 cycles. The AREF command is on the pins exactly once, in the 2nd S_AREF cycle. All other cycles show NOP.
- Async reset mid-operation: all state, counters and grants return to reset values immediately; the pins revert to the init mux.

## Configuration
- `SDRAM_ARB_RR_EN` defined:
  - 1-bit `last_rd` register, reset value 0. It is set on S_ARBIT→S_READ and cleared on S_ARBIT→S_WRITE.
  - When `wr_req` and `rd_req` are both high in S_ARBIT, the engine not served last wins.
  - Refresh priority is unchanged.
- Not defined: fixed priority, write over read. `last_rd` is absent.

## Test plan
- Reset, then `init_end`=1 at cycle 100 → S_ARBIT at cycle 101. Pins read NOP 0111, addr 0, bank 0; `wr_en`=`rd_en`=0.
- REF_INTERVAL=390, TRFC=7, no requests → `ref_req` rises 390 cycles after S_ARBIT entry. S_AREF is entered the next cycle and `ref_req` falls. Pins show 0001 exactly once. S_ARBIT follows 8 cycles after S_AREF entry. Repeats every 390 cycles.
- `wr_req`=`rd_req`=1 continuously, each engine ending after 20 cycles:
  - Macro undefined → only `wr_en` ever granted.
  - Macro defined → grants alternate write, read, write, read.
- In S_READ, `ref_req` rises while `wr_req`=1 → `rd_en` stays high until `flag_rd_end`. Then S_ARBIT, then S_AREF, then S_WRITE.
- In S_READ, `rd_cmd`=0101, `rd_addr`=0x012, `rd_bank_addr`=2 → same cycle: pins 0/1/0/1, addr 0x012, bank 2.
- `s_rst_n` pulsed low mid-S_WRITE → `wr_en`=0 immediately, state S_INIT, `ref_req`=0. No grant until `init_end` is seen again.

Source files
------------

// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command arbiter with built-in periodic auto-refresh.
// Define SDRAM_ARB_RR_EN for round-robin write/read arbitration.
module sdram_arbit #(
  parameter int REF_INTERVAL = 390,
  parameter int TRFC         = 7
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        wr_req,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank_addr,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank_addr,
  output logic        rd_en,
  output logic        ref_req,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_bank,
  output logic [12:0] sdram_addr
);
  localparam int RW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int AW = $clog2(TRFC + 1);
  localparam logic [RW-1:0] REF_MAX = RW'(REF_INTERVAL - 1);
  localparam logic [AW-1:0] AREF_MAX = AW'(TRFC);
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int I_INIT  = 0;
  localparam int I_ARBIT = 1;
  localparam int I_AREF  = 2;
  localparam int I_WRITE = 3;
  localparam int I_READ  = 4;

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [AW-1:0]   aref_cnt_q, aref_cnt_d;
  logic            ref_req_q, ref_req_d;
  logic [3:0]      aref_cmd_q, aref_cmd_d;
  logic            wr_pick;
  logic [3:0]      cmd;

`ifdef SDRAM_ARB_RR_EN
  logic last_rd_q, last_rd_d;
  // On contention the engine not served last wins.
  assign wr_pick = wr_req && (!rd_req || last_rd_q);
`else
  assign wr_pick = wr_req;
`endif

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[I_INIT]: if (init_end) state_d = S_ARBIT;
      state_q[I_ARBIT]: begin
        if (ref_req_q)    state_d = S_AREF;
        else if (wr_pick) state_d = S_WRITE;
        else if (rd_req)  state_d = S_READ;
      end
      state_q[I_AREF]: if (aref_cnt_q == AREF_MAX) state_d = S_ARBIT;
      state_q[I_WRITE]: if (flag_wr_end) state_d = S_ARBIT;
      state_q[I_READ]: if (flag_rd_end) state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    ref_cnt_d = '0;
    if (state_q != S_INIT && ref_cnt_q != REF_MAX)
      ref_cnt_d = ref_cnt_q + 1'b1;
    ref_req_d = ref_req_q;
    if (ref_cnt_q == REF_MAX)
      ref_req_d = 1'b1;
    else if (state_q == S_ARBIT)
      ref_req_d = 1'b0;
    aref_cnt_d = '0;
    if (state_q == S_AREF && aref_cnt_q != AREF_MAX)
      aref_cnt_d = aref_cnt_q + 1'b1;
    aref_cmd_d = CMD_NOP;
    if (state_q == S_AREF && aref_cnt_q == '0)
      aref_cmd_d = CMD_AREF;
  end

`ifdef SDRAM_ARB_RR_EN
  always_comb begin
    last_rd_d = last_rd_q;
    if (state_q == S_ARBIT && state_d == S_READ)  last_rd_d = 1'b1;
    if (state_q == S_ARBIT && state_d == S_WRITE) last_rd_d = 1'b0;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) last_rd_q <= 1'b0;
    else          last_rd_q <= last_rd_d;
  end
`endif

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= S_INIT;
      ref_cnt_q  <= '0;
      aref_cnt_q <= '0;
      ref_req_q  <= 1'b0;
      aref_cmd_q <= CMD_NOP;
    end else begin
      state_q    <= state_d;
      ref_cnt_q  <= ref_cnt_d;
      aref_cnt_q <= aref_cnt_d;
      ref_req_q  <= ref_req_d;
      aref_cmd_q <= aref_cmd_d;
    end
  end

  // Zero-latency mux keeps the read engine's CAS alignment intact.
  always_comb begin
    cmd        = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    unique case (1'b1)
      state_q[I_INIT]: begin
        cmd        = init_cmd;
        sdram_addr = init_addr;
      end
      state_q[I_AREF]: cmd = aref_cmd_q;
      state_q[I_WRITE]: begin
        cmd        = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank_addr;
      end
      state_q[I_READ]: begin
        cmd        = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank_addr;
      end
      default: cmd = CMD_NOP;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;
  assign wr_en     = (state_q == S_WRITE);
  assign rd_en     = (state_q == S_READ);
  assign ref_req   = ref_req_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed bench for sdram_arbit.
// Define SDRAM_ARB_RR_EN to check round-robin arbitration.
module tb_sdram_arbit;
  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0111;
  logic [12:0] init_addr = '0;
  logic        wr_req = 1'b0;
  logic        flag_wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0111;
  logic [12:0] wr_addr = '0;
  logic [1:0]  wr_bank_addr = '0;
  logic        wr_en;
  logic        rd_req = 1'b0;
  logic        flag_rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0111;
  logic [12:0] rd_addr = '0;
  logic [1:0]  rd_bank_addr = '0;
  logic        rd_en;
  logic        ref_req;
  logic        sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_bank;
  logic [12:0] sdram_addr;
  logic [3:0]  pin_cmd;

  int checks = 0;
  int fails = 0;

  assign pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  always #5 sclk = ~sclk;

  sdram_arbit #(.REF_INTERVAL(390), .TRFC(7)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd),
    .wr_addr(wr_addr), .wr_bank_addr(wr_bank_addr), .wr_en(wr_en),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd),
    .rd_addr(rd_addr), .rd_bank_addr(rd_bank_addr), .rd_en(rd_en),
    .ref_req(ref_req), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
  );

  task automatic step();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0;
    #12;
    checks++;
    if ({pin_cmd, sdram_addr, sdram_bank} !== {4'b0111, 13'h0, 2'd0}) begin
      fails++;
      $display("FAIL reset_pins: got cmd=%b addr=%h bank=%0d want 0111/0/0",
               pin_cmd, sdram_addr, sdram_bank);
    end
    checks++;
    if ({wr_en, rd_en, ref_req, sdram_cke} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_ctl: got wr/rd/ref/cke=%b want 0001",
               {wr_en, rd_en, ref_req, sdram_cke});
    end
    init_cmd = 4'b0010;
    init_addr = 13'h400;
    #1;
    checks++;
    if ({pin_cmd, sdram_addr} !== {4'b0010, 13'h400}) begin
      fails++;
      $display("FAIL init_mux: got cmd=%b addr=%h want 0010/400",
               pin_cmd, sdram_addr);
    end
  endtask

  task automatic test_init_exit();
    @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (100) step();
    checks++;
    if ({pin_cmd, sdram_addr, wr_en, rd_en} !== {4'b0010, 13'h400, 2'b00}) begin
      fails++;
      $display("FAIL init_hold: got cmd=%b addr=%h wr/rd=%b%b want 0010/400/00",
               pin_cmd, sdram_addr, wr_en, rd_en);
    end
    init_end = 1'b1;
    step();
    checks++;
    if ({pin_cmd, sdram_addr, sdram_bank, wr_en, rd_en} !==
        {4'b0111, 13'h0, 2'd0, 2'b00}) begin
      fails++;
      $display("FAIL arbit_entry: got cmd=%b addr=%h bank=%0d wr/rd=%b%b want 0111/0/0/00",
               pin_cmd, sdram_addr, sdram_bank, wr_en, rd_en);
    end
  endtask

  task automatic test_refresh();
    int n;
    int aref_seen;
    int aref_pos;
    int first_wr;
    n = 0;
    while (ref_req !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    checks++;
    if (n != 390) begin
      fails++;
      $display("FAIL ref_interval: got %0d cycles want 390", n);
    end
    wr_req = 1'b1;
    wr_cmd = 4'b0100;
    wr_addr = 13'h155;
    wr_bank_addr = 2'd1;
    step();
    checks++;
    if ({ref_req, pin_cmd, wr_en} !== {1'b0, 4'b0111, 1'b0}) begin
      fails++;
      $display("FAIL aref_entry: got ref=%b cmd=%b wr=%b want 0/0111/0",
               ref_req, pin_cmd, wr_en);
    end
    aref_seen = 0;
    aref_pos = -1;
    first_wr = -1;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (first_wr < 0 && wr_en === 1'b1) first_wr = j;
      if (j <= 8 && pin_cmd === 4'b0001) begin
        aref_seen++;
        aref_pos = j;
      end
    end
    checks++;
    if (aref_seen != 1 || aref_pos != 1) begin
      fails++;
      $display("FAIL aref_cmd: got count=%0d pos=%0d want 1/1", aref_seen, aref_pos);
    end
    checks++;
    if (first_wr != 9) begin
      fails++;
      $display("FAIL aref_dwell: got write grant at %0d want 9", first_wr);
    end
    checks++;
    if ({pin_cmd, sdram_addr, sdram_bank} !== {4'b0100, 13'h155, 2'd1}) begin
      fails++;
      $display("FAIL wr_mux: got cmd=%b addr=%h bank=%0d want 0100/155/1",
               pin_cmd, sdram_addr, sdram_bank);
    end
    wr_cmd = 4'b0011;
    #1;
    checks++;
    if (pin_cmd !== 4'b0011) begin
      fails++;
      $display("FAIL wr_mux_lat: got cmd=%b want 0011", pin_cmd);
    end
    @(negedge sclk);
    flag_wr_end = 1'b1;
    wr_req = 1'b0;
    step();
    flag_wr_end = 1'b0;
    checks++;
    if ({wr_en, rd_en} !== 2'b00) begin
      fails++;
      $display("FAIL wr_release: got wr/rd=%b%b want 00", wr_en, rd_en);
    end
  endtask

  task automatic test_ref_during_read();
    int n;
    int drops;
    int first_wr;
    rd_req = 1'b1;
    n = 0;
    while (rd_en !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 1) begin
      fails++;
      $display("FAIL rd_latency: got %0d cycles want 1", n);
    end
    wr_req = 1'b1;
    wr_cmd = 4'b0100;
    rd_cmd = 4'b0101;
    rd_addr = 13'h012;
    rd_bank_addr = 2'd2;
    #1;
    checks++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr, sdram_bank} !==
        {4'b0101, 13'h012, 2'd2}) begin
      fails++;
      $display("FAIL rd_mux: got cmd=%b addr=%h bank=%0d want 0101/012/2",
               pin_cmd, sdram_addr, sdram_bank);
    end
    n = 0;
    drops = 0;
    while (ref_req !== 1'b1 && n < 800) begin
      step();
      n++;
      if (rd_en !== 1'b1 || wr_en !== 1'b0) drops++;
    end
    repeat (3) begin
      step();
      if (rd_en !== 1'b1 || wr_en !== 1'b0) drops++;
    end
    checks++;
    if (ref_req !== 1'b1 || drops != 0) begin
      fails++;
      $display("FAIL rd_no_preempt: got ref=%b drops=%0d want 1/0", ref_req, drops);
    end
    flag_rd_end = 1'b1;
    rd_req = 1'b0;
    step();
    flag_rd_end = 1'b0;
    checks++;
    if ({wr_en, rd_en, ref_req, pin_cmd, sdram_addr} !==
        {3'b001, 4'b0111, 13'h0}) begin
      fails++;
      $display("FAIL rd_to_arbit: got wr/rd/ref=%b cmd=%b addr=%h want 001/0111/0",
               {wr_en, rd_en, ref_req}, pin_cmd, sdram_addr);
    end
    step();
    checks++;
    if ({wr_en, rd_en, ref_req} !== 3'b000) begin
      fails++;
      $display("FAIL ref_wins: got wr/rd/ref=%b want 000", {wr_en, rd_en, ref_req});
    end
    first_wr = -1;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (first_wr < 0 && wr_en === 1'b1) first_wr = j;
    end
    checks++;
    if (first_wr != 9) begin
      fails++;
      $display("FAIL ref_then_write: got write grant at %0d want 9", first_wr);
    end
    flag_wr_end = 1'b1;
    wr_req = 1'b0;
    step();
    flag_wr_end = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    logic gap_ref;
    logic [3:0] kind;
    wr_req = 1'b1;
    rd_req = 1'b1;
    bad = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (wr_en !== 1'b1 && rd_en !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      kind[g] = wr_en;
      if (wr_en === rd_en) bad++;
      repeat (19) begin
        step();
        if (wr_en !== kind[g] || rd_en !== ~kind[g]) bad++;
      end
      if (g == 3) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
      flag_wr_end = 1'b1;
      flag_rd_end = 1'b1;
      step();
      flag_wr_end = 1'b0;
      flag_rd_end = 1'b0;
      if ({wr_en, rd_en} !== 2'b00) bad++;
      gap_ref = ref_req;
      if (g < 3) begin
        step();
        if (!gap_ref && wr_en !== 1'b1 && rd_en !== 1'b1) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b2b_handshake: got %0d grant errors want 0", bad);
    end
`ifdef SDRAM_ARB_RR_EN
    checks++;
    if (kind[0] == kind[1] || kind[1] == kind[2] || kind[2] == kind[3]) begin
      fails++;
      $display("FAIL b2b_rr: got grant pattern (1=write) %b want alternating", kind);
    end
`else
    checks++;
    if (kind !== 4'b1111) begin
      fails++;
      $display("FAIL b2b_fixed: got grant pattern (1=write) %b want 1111", kind);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    int n;
    wr_req = 1'b1;
    n = 0;
    while (wr_en !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (wr_en !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_write: got wr=%b want 1", wr_en);
    end
    s_rst_n = 1'b0;
    init_end = 1'b0;
    #1;
    checks++;
    if ({wr_en, rd_en, ref_req, pin_cmd, sdram_addr, sdram_bank} !==
        {3'b000, 4'b0010, 13'h400, 2'd0}) begin
      fails++;
      $display("FAIL async_reset: got wr/rd/ref=%b cmd=%b addr=%h bank=%0d want 000/0010/400/0",
               {wr_en, rd_en, ref_req}, pin_cmd, sdram_addr, sdram_bank);
    end
    repeat (2) step();
    s_rst_n = 1'b1;
    repeat (20) step();
    checks++;
    if ({wr_en, pin_cmd} !== {1'b0, 4'b0010}) begin
      fails++;
      $display("FAIL no_grant_in_init: got wr=%b cmd=%b want 0/0010", wr_en, pin_cmd);
    end
    init_end = 1'b1;
    step();
    checks++;
    if ({wr_en, pin_cmd} !== {1'b0, 4'b0111}) begin
      fails++;
      $display("FAIL reinit_arbit: got wr=%b cmd=%b want 0/0111", wr_en, pin_cmd);
    end
    step();
    checks++;
    if (wr_en !== 1'b1) begin
      fails++;
      $display("FAIL reinit_grant: got wr=%b want 1", wr_en);
    end
    flag_wr_end = 1'b1;
    wr_req = 1'b0;
    step();
    flag_wr_end = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_exit();
    test_refresh();
    test_ref_during_read();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
